cla_sliced_add_sub_seq: RTL and testbench
=========================================

Name: cla_sliced_add_sub_seq

Overview:
Multi-cycle signed adder/subtractor for wide operands. It feeds one SLICE_W-bit carry-lookahead adder slice per cycle and chains the carry through a register between slices. It captures each slice sum and, on the last slice, produces the result and signed flags. The block sits between an operand producer (valid/ready) and a result consumer (valid/ready). It is the sequencing wrapper around the existing CLA unit adder.

Parameters:
DATA_W, 16, operand/result width in bits; must be an integer multiple of SLICE_W
SLICE_W, 4, width of the CLA slice processed per cycle
NUM_SLICES, DATA_W/SLICE_W, derived (localparam), slice count per operation

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous reset, active-high
in_valid_i  input  1  operand request valid
in_ready_o  output  1  block can accept an operand request
op_sub_i  input  1  0 = A+B, 1 = A-B
inp_A_i  input  DATA_W  operand A, two's complement
inp_B_i  input  DATA_W  operand B, two's complement
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
result_o  output  DATA_W  A±B modulo 2^DATA_W
carry_o  output  1  final carry out; for subtract, 1 = no borrow
overflow_o  output  1  signed overflow
zero_o  output  1  result_o == 0
negative_o  output  1  result_o[DATA_W-1]

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high on rst_i. No async reset.
- Reset values:
  - state = IDLE, slice counter = 0, carry register = 0.
  - out_valid_o = 0; result_o, carry_o, overflow_o, zero_o, negative_o = 0.
  - in_ready_o = 0 while rst_i is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o = 1.
  - On in_valid_i & in_ready_o: latch A into a_reg and B into b_reg, with b_reg = ~B when op_sub_i=1.
  - Same edge: carry register = op_sub_i, counter = 0, state goes to RUN.
- RUN:
  - in_ready_o = 0.
  - The slice adder sees a_reg[k*SLICE_W +: SLICE_W], b_reg[same slice] and the carry register, where k = counter.
  - Each edge: write the slice sum into result[k slice], load the carry register with the slice carry out, counter += 1.
  - When k == NUM_SLICES-1, on that edge:
    - state goes to DONE and out_valid_o goes to 1.
    - carry_o = slice carry out.
    - overflow_o = (a_reg[MSB] == b_reg[MSB]) & (sum[MSB] != a_reg[MSB]), using the inverted B.
    - zero_o and negative_o are computed from the complete result.
- DONE:
  - in_ready_o = 0.
  - All outputs are held stable while out_ready_i = 0.
  - On out_ready_i = 1: out_valid_o goes to 0 and state goes to IDLE.
  - No same-cycle accept of a new operand.
- Latency: out_valid_o rises NUM_SLICES edges after the accept edge (4 for defaults).
- Throughput: one operation per NUM_SLICES+2 cycles with out_ready_i held high.
- Inputs are sampled only at the accept edge. Changes on inp_A_i, inp_B_i or op_sub_i during RUN/DONE have no effect. in_valid_i outside IDLE is ignored.
- Counter wraps to 0 on DONE to IDLE. Its width is $clog2(NUM_SLICES), minimum 1.
- Reset mid-RUN or mid-DONE aborts the operation. Every register returns to its reset value on that edge and no partial result is ever presented.
- result_o/flags keep their last values after the DONE to IDLE handshake. They are meaningful only while out_valid_o = 1.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the OP_ADD/OP_SUB constants;
  - the counter-width function/localparam.
- Elaboration check: DATA_W % SLICE_W == 0.
- One sub-module: carry_lookahead_unit_adder, instantiated with DATA_IN_W = SLICE_W.
  - Its group propagate/generate outputs are left unconnected.
  - The carry chaining lives in this block's register.

Test Plan:
All cases use DATA_W=16, SLICE_W=4.
- Add 0x1234 + 0x0FED -> result 0x2221, carry 0, ovf 0, zero 0, neg 0; out_valid_o exactly 4 edges after accept.
- Add 0x7FFF + 0x0001 -> 0x8000, ovf 1, neg 1, carry 0. Add 0xFFFF + 0x0001 -> 0x0000, carry 1, zero 1, ovf 0.
- Sub 0x0005 - 0x0005 -> 0x0000, zero 1, carry 1, ovf 0. Sub 0x8000 - 0x0001 -> 0x7FFF, ovf 1, carry 1, neg 0. Sub 0x0000 - 0x0001 -> 0xFFFF, carry 0, neg 1.
- Backpressure: hold out_ready_i=0 for 3 cycles after out_valid_o while driving in_valid_i=1 with new operands.
  - Required: result and flags stable, in_ready_o=0, new operands not taken.
  - Release out_ready_i: IDLE next cycle, then the new op is accepted and computed correctly.
- Operand change during RUN: drive different inp_A_i/inp_B_i/op_sub_i each RUN cycle -> result equals the values latched at accept.
- Reset mid-op: assert rst_i one cycle after 2 slices are done -> next edge out_valid_o=0, outputs 0, in_ready_o=1 once rst_i drops. The following op 0x00FF + 0x0001 returns 0x0100.

Source files
------------

// File: rtl/cla_sliced_add_sub_seq_pkg.sv
// -----------------------------------------------------------------------------
// cla_sliced_add_sub_seq_pkg
// Shared definitions for the sliced CLA adder/subtractor:
//   - FSM state encoding (IDLE / RUN / DONE)
//   - operation select constants (OP_ADD / OP_SUB)
//   - slice-counter width helper (never narrower than 1 bit)
// -----------------------------------------------------------------------------
package cla_sliced_add_sub_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Counter must be able to index every slice; a single slice still gets a 1-bit counter.
    function automatic int cnt_width(input int num_slices);
        return (num_slices > 1) ? $clog2(num_slices) : 1;
    endfunction

endpackage

// File: rtl/cla_sliced_add_sub_seq_adder.sv
// -----------------------------------------------------------------------------
// carry_lookahead_unit_adder
// Combinational carry-lookahead adder of DATA_IN_W bits.
// Ports:
//   a_in, b_in  : addends
//   carry_in    : carry into bit 0
//   sum         : a_in + b_in + carry_in (low DATA_IN_W bits)
//   carry_out   : carry out of the top bit
//   group_g     : group generate (carry out independent of carry_in)
//   group_p     : group propagate (carry_in passes through all bits)
// -----------------------------------------------------------------------------
module carry_lookahead_unit_adder #(
    parameter int DATA_IN_W = 4
) (
    input  logic [DATA_IN_W-1:0] a_in,
    input  logic [DATA_IN_W-1:0] b_in,
    input  logic                 carry_in,
    output logic [DATA_IN_W-1:0] sum,
    output logic                 carry_out,
    output logic                 group_g,
    output logic                 group_p
);

    logic [DATA_IN_W-1:0] gen;
    logic [DATA_IN_W-1:0] prop;
    logic [DATA_IN_W:0]   carry;
    logic [DATA_IN_W:0]   gen_part;

    // Each carry is expanded as a flat sum of products of g/p terms, so no
    // carry depends on the previous one (true lookahead, not ripple).
    always_comb begin
        logic term;
        logic cin_path;
        gen      = a_in & b_in;
        prop     = a_in ^ b_in;
        carry    = '0;
        gen_part = '0;
        term     = 1'b0;
        cin_path = 1'b0;
        carry[0] = carry_in;
        for (int i = 0; i < DATA_IN_W; i++) begin
            for (int j = 0; j <= i; j++) begin
                term = gen[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & prop[k];
                end
                gen_part[i+1] = gen_part[i+1] | term;
            end
            cin_path = carry_in;
            for (int j = 0; j <= i; j++) begin
                cin_path = cin_path & prop[j];
            end
            carry[i+1] = gen_part[i+1] | cin_path;
        end
        sum       = prop ^ carry[DATA_IN_W-1:0];
        carry_out = carry[DATA_IN_W];
        group_g   = gen_part[DATA_IN_W];
        group_p   = &prop;
    end

endmodule

// File: rtl/cla_sliced_add_sub_seq.sv
// -----------------------------------------------------------------------------
// cla_sliced_add_sub_seq
// Multi-cycle signed adder/subtractor. One SLICE_W-bit CLA slice is evaluated
// per clock, least-significant slice first; the inter-slice carry lives in a
// register. Subtraction is A + ~B + 1 (carry register seeded with 1).
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   in_valid_i / in_ready_o   : operand handshake (accepted only in IDLE)
//   op_sub_i                  : 0 = A+B, 1 = A-B
//   inp_A_i, inp_B_i          : two's complement operands
//   out_valid_o / out_ready_i : result handshake (held in DONE)
//   result_o                  : A +/- B modulo 2^DATA_W
//   carry_o                   : final carry (subtract: 1 = no borrow)
//   overflow_o                : signed overflow
//   zero_o, negative_o        : result == 0, result sign bit
// -----------------------------------------------------------------------------
module cla_sliced_add_sub_seq
    import cla_sliced_add_sub_seq_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              op_sub_i,
    input  logic [DATA_W-1:0] inp_A_i,
    input  logic [DATA_W-1:0] inp_B_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              overflow_o,
    output logic              zero_o,
    output logic              negative_o
);

    localparam int NUM_SLICES = DATA_W / SLICE_W;
    localparam int CNT_W      = cnt_width(NUM_SLICES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

    generate
        if (DATA_W % SLICE_W != 0) begin : g_width_check
            $error("DATA_W must be an integer multiple of SLICE_W");
        end
    endgenerate

    // Signed overflow: operands (B already inverted for subtract) share a sign
    // and the result sign differs from it.
    function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              carry_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic [DATA_W-1:0]  res_next;

    // Group generate/propagate are not needed: the carry chains through carry_q.
    logic slice_g_unused;
    logic slice_p_unused;

    assign in_ready_o = (state_q == IDLE) && !rst_i;

    always_comb begin
        int base;
        base     = int'(cnt_q) * SLICE_W;
        slice_a  = a_q[base +: SLICE_W];
        slice_b  = b_q[base +: SLICE_W];
        res_next = result_o;
        res_next[base +: SLICE_W] = slice_sum;
    end

    carry_lookahead_unit_adder #(
        .DATA_IN_W (SLICE_W)
    ) u_slice_adder (
        .a_in      (slice_a),
        .b_in      (slice_b),
        .carry_in  (carry_q),
        .sum       (slice_sum),
        .carry_out (slice_cout),
        .group_g   (slice_g_unused),
        .group_p   (slice_p_unused)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_o <= 1'b0;
            result_o    <= '0;
            carry_o     <= 1'b0;
            overflow_o  <= 1'b0;
            zero_o      <= 1'b0;
            negative_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q     <= inp_A_i;
                        b_q     <= (op_sub_i == OP_ADD) ? inp_B_i : ~inp_B_i;
                        carry_q <= (op_sub_i == OP_SUB);
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    result_o <= res_next;
                    carry_q  <= slice_cout;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= DONE;
                        out_valid_o <= 1'b1;
                        carry_o     <= slice_cout;
                        overflow_o  <= ovf_flag(a_q[DATA_W-1], b_q[DATA_W-1], slice_sum[SLICE_W-1]);
                        zero_o      <= (res_next == '0);
                        negative_o  <= res_next[DATA_W-1];
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_sliced_add_sub_seq.sv
// -----------------------------------------------------------------------------
// tb_cla_sliced_add_sub_seq
// Self-checking bench for cla_sliced_add_sub_seq (DATA_W=16, SLICE_W=4):
// directed vector table, backpressure / operand-change / mid-op reset
// sequences, and randomized operations against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_cla_sliced_add_sub_seq;

    localparam int DATA_W  = 16;
    localparam int SLICE_W = 4;
    localparam int LATENCY = DATA_W / SLICE_W;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              op_sub_i;
    logic [DATA_W-1:0] inp_A_i;
    logic [DATA_W-1:0] inp_B_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] result_o;
    logic              carry_o;
    logic              overflow_o;
    logic              zero_o;
    logic              negative_o;

    int checks = 0;
    int errors = 0;

    cla_sliced_add_sub_seq #(
        .DATA_W  (DATA_W),
        .SLICE_W (SLICE_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_sub_i    (op_sub_i),
        .inp_A_i     (inp_A_i),
        .inp_B_i     (inp_B_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .carry_o     (carry_o),
        .overflow_o  (overflow_o),
        .zero_o      (zero_o),
        .negative_o  (negative_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the operands themselves.
    task automatic model(input logic sub, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic c, output logic v,
                         output logic z, output logic n);
        int          sa, sb, s;
        int unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        if (sub) begin
            s = sa - sb;
            c = (ua >= ub);
            r = 16'(ua - ub);
        end else begin
            s = sa + sb;
            c = ((ua + ub) > 32'd65535);
            r = 16'(ua + ub);
        end
        v = (s > 32767) || (s < -32768);
        z = (r == 16'h0000);
        n = r[15];
    endtask

    task automatic start_op(input logic sub, input logic [15:0] a, input logic [15:0] b);
        int w;
        w = 0;
        while (!in_ready_o && w < 20) begin
            tick();
            w++;
        end
        check("in_ready_before_accept", 32'(in_ready_o), 32'd1);
        op_sub_i   = sub;
        inp_A_i    = a;
        inp_B_i    = b;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
    endtask

    // Scrambles the operand inputs every RUN cycle; they must not matter.
    task automatic wait_result(input string name);
        int lat;
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            inp_A_i  = 16'($urandom);
            inp_B_i  = 16'($urandom);
            op_sub_i = 1'($urandom);
            check({name, "_in_ready_busy"}, 32'(in_ready_o), 32'd0);
            tick();
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(LATENCY));
    endtask

    task automatic check_out(input string name, input logic [15:0] r, input logic c,
                             input logic v, input logic z, input logic n);
        check({name, "_valid"},  32'(out_valid_o), 32'd1);
        check({name, "_result"}, 32'(result_o),    32'(r));
        check({name, "_flags"},  {28'd0, carry_o, overflow_o, zero_o, negative_o},
                                 {28'd0, c, v, z, n});
    endtask

    task automatic finish_op(input string name);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check({name, "_valid_drop"}, 32'(out_valid_o), 32'd0);
    endtask

    initial begin
        logic [15:0] er;
        logic        ec, ev, ez, en;
        logic [15:0] held_res;
        logic [3:0]  held_flags;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FED, 16'h2221, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        op_sub_i    = 1'b0;
        inp_A_i     = '0;
        inp_B_i     = '0;
        out_ready_i = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_in_ready",  32'(in_ready_o),  32'd0);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_result",    32'(result_o),    32'd0);
        check("rst_flags", {28'd0, carry_o, overflow_o, zero_o, negative_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready_o), 32'd1);

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].sub, vecs[i].a, vecs[i].b);
            wait_result($sformatf("vec%0d", i));
            check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].v,
                      vecs[i].z, vecs[i].n);
            finish_op($sformatf("vec%0d", i));
        end

        // Backpressure with a new request pending
        start_op(1'b0, 16'h1234, 16'h0FED);
        wait_result("bp");
        held_res   = result_o;
        held_flags = {carry_o, overflow_o, zero_o, negative_o};
        check("bp_result_first", 32'(held_res), 32'h2221);
        in_valid_i = 1'b1;
        op_sub_i   = 1'b1;
        inp_A_i    = 16'h0100;
        inp_B_i    = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid",    32'(out_valid_o), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready_o),  32'd0);
            check("bp_hold_result",   32'(result_o),    32'(held_res));
            check("bp_hold_flags", {28'd0, carry_o, overflow_o, zero_o, negative_o},
                                   {28'd0, held_flags});
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("bp_release_valid", 32'(out_valid_o), 32'd0);
        check("bp_release_idle",  32'(in_ready_o),  32'd1);
        tick();
        in_valid_i = 1'b0;
        check("bp_new_accepted", 32'(in_ready_o), 32'd0);
        wait_result("bp_new");
        check_out("bp_new", 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_op("bp_new");

        // Reset in the middle of an operation
        start_op(1'b0, 16'h1234, 16'h1111);
        tick();
        tick();
        rst_i = 1'b1;
        #1;
        check("midrst_in_ready_low", 32'(in_ready_o), 32'd0);
        tick();
        check("midrst_valid",  32'(out_valid_o), 32'd0);
        check("midrst_result", 32'(result_o),    32'd0);
        check("midrst_flags", {28'd0, carry_o, overflow_o, zero_o, negative_o}, 32'd0);
        tick();
        check("midrst_valid_stays", 32'(out_valid_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("midrst_in_ready_back", 32'(in_ready_o), 32'd1);
        start_op(1'b0, 16'h00FF, 16'h0001);
        wait_result("after_rst");
        check_out("after_rst", 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("after_rst");

        // Randomized operations with variable consumer delay
        for (int i = 0; i < 40; i++) begin
            logic        s;
            logic [15:0] a, b;
            int          dly;
            s   = 1'($urandom);
            a   = 16'($urandom);
            b   = 16'($urandom);
            if (i % 8 == 0) b = a;
            if (i % 8 == 1) a = 16'h8000;
            dly = $urandom_range(0, 2);
            model(s, a, b, er, ec, ev, ez, en);
            start_op(s, a, b);
            wait_result("rnd");
            repeat (dly) tick();
            check_out($sformatf("rnd%0d", i), er, ec, ev, ez, en);
            finish_op("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
